// File: rtl/seg7_scan_reader_pkg.sv
// Shared constants and types for the 7-segment readback path: segment code
// table (same codes as the hex->7-segment encoder) and the scan FSM states.
package seg7_pkg;

  // All segments off on an active-low bus.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} code for nibble values 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_HELD
  } scan_state_t;

  // Width of a digit index; a single-digit display still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Snooped display bus plus decoded readback results. The master side drives
// the display bus and observes results; the slave side is the reader.
interface seg7_scan_reader_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  localparam int IDX_W = idx_width(NUM_DIGITS);

  logic                    sample_en;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [6:0]              seg_in;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_done;
  logic                    pattern_err;
  logic [IDX_W-1:0]        err_digit;

  modport master (
    output sample_en, an_in, seg_in,
    input  digits, digit_valid, frame_done, pattern_err, err_digit
  );

  modport slave (
    input  sample_en, an_in, seg_in,
    output digits, digit_valid, frame_done, pattern_err, err_digit
  );

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex->7-segment encoder. hit marks one of the
// sixteen legal codes, blank marks all segments off; anything else is neither.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] nibble
);

  // Table lookup against the shared encoder codes.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit    = 1'b0;
    nibble = 4'h0;
    blank  = (seg == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each digit's
// pattern over STABLE_CNT qualified samples and commits the decoded nibble.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_reader_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  scan_state_t             state, state_n;
  logic [IDX_W-1:0]        cand_idx, cand_idx_n, sample_idx;
  logic [6:0]              cand_seg, cand_seg_n;
  logic [CNT_W-1:0]        count, count_n;
  logic [NUM_DIGITS-1:0]   an_low, an_low_m1, mask, mask_set;
  logic                    one_hot, qualified, same, commit;
  logic                    dec_hit, dec_blank;
  logic [3:0]              dec_nibble;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic                    frame_q, err_q;
  logic [IDX_W-1:0]        err_idx_q;

  // Anode check: exactly one low enable, and its index.
  always_comb begin
    an_low     = ~bus.an_in;
    an_low_m1  = an_low - NUM_DIGITS'(1);
    one_hot    = (an_low != '0) && ((an_low & an_low_m1) == '0);
    sample_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) sample_idx = IDX_W'(i);
    end
    qualified  = bus.sample_en && one_hot;
    same       = (sample_idx == cand_idx) && (bus.seg_in == cand_seg);
  end

  // The committed candidate is the registered one, equal to the current sample.
  seg7_to_hex u_dec (
    .seg    (cand_seg),
    .hit    (dec_hit),
    .blank  (dec_blank),
    .nibble (dec_nibble)
  );

  // Scan FSM, candidate and stability-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cand_idx <= '0;
      cand_seg <= SEG_BLANK;
      count    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= state_n;
      cand_idx <= cand_idx_n;
      cand_seg <= cand_seg_n;
      count    <= count_n;
    end
  end

  // Next-state logic: track, debounce and decide when to commit.
  always_comb begin
    state_n    = state;
    cand_idx_n = cand_idx;
    cand_seg_n = cand_seg;
    count_n    = count;
    commit     = 1'b0;
    if (bus.sample_en) begin
      if (!one_hot) begin
        state_n = S_IDLE;
        count_n = '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            cand_idx_n = sample_idx;
            cand_seg_n = bus.seg_in;
            count_n    = CNT_W'(1);
            state_n    = S_TRACK;
          end
          S_TRACK: begin
            if (same) begin
              if (count < CNT_W'(STABLE_CNT)) count_n = count + CNT_W'(1);
              if (count == CNT_W'(STABLE_CNT - 1)) begin
                commit  = 1'b1;
                state_n = S_HELD;
              end
            end else begin
              cand_idx_n = sample_idx;
              cand_seg_n = bus.seg_in;
              count_n    = CNT_W'(1);
            end
          end
          S_HELD: begin
            if (!same) begin
              cand_idx_n = sample_idx;
              cand_seg_n = bus.seg_in;
              count_n    = CNT_W'(1);
              state_n    = S_TRACK;
            end
          end
          default: begin
            state_n = S_IDLE;
            count_n = '0;
          end
        endcase
      end
    end
  end

  // Frame mask with the committing digit added.
  always_comb begin
    mask_set = mask | (NUM_DIGITS'(1) << cand_idx);
  end

  // Commit registers: digit values, validity, frame tracking and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q  <= '0;
      valid_q   <= '0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      mask      <= '0;
    end else begin
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      if (commit) begin
        if (dec_hit) begin
          digits_q[int'(cand_idx)*4 +: 4] <= dec_nibble;
          valid_q[cand_idx]               <= 1'b1;
        end else begin
          valid_q[cand_idx] <= 1'b0;
          if (!dec_blank) begin
            err_q     <= 1'b1;
            err_idx_q <= cand_idx;
          end
        end
        if (&mask_set) begin
          frame_q <= 1'b1;
          mask    <= '0;
        end else begin
          mask <= mask_set;
        end
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_q;
  assign bus.pattern_err = err_q;
  assign bus.err_digit   = err_idx_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: each drive step pushes the expected
// post-edge outputs to a scoreboard, popped and compared after the edge.
module tb_seg7_scan_reader;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  seg7_scan_reader_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CNT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  v;
    logic        fd;
    logic        pe;
    logic [1:0]  ed;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] cur_d;
  logic [3:0]  cur_v;
  logic [1:0]  cur_ed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; expectation queued at drive time, checked after the edge.
  task automatic step(input logic en, input logic [3:0] an, input logic [6:0] seg,
                      input logic fd, input logic pe);
    exp_t e;
    @(negedge clk);
    bus.sample_en = en;
    bus.an_in     = an;
    bus.seg_in    = seg;
    e.d = cur_d; e.v = cur_v; e.fd = fd; e.pe = pe; e.ed = cur_ed;
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty step%0d observed=0 expected=1", step_no);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("step%0d_digits", step_no), 32'(bus.digits), 32'(e.d));
      check($sformatf("step%0d_valid", step_no), 32'(bus.digit_valid), 32'(e.v));
      check($sformatf("step%0d_frame_done", step_no), 32'(bus.frame_done), 32'(e.fd));
      check($sformatf("step%0d_pattern_err", step_no), 32'(bus.pattern_err), 32'(e.pe));
      check($sformatf("step%0d_err_digit", step_no), 32'(bus.err_digit), 32'(e.ed));
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    repeat (n) step(1'b1, an, seg, 1'b0, 1'b0);
  endtask

  // sample_en low with garbage on the bus: must be ignored.
  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'b0000, 7'h55, 1'b0, 1'b0);
  endtask

  // Fresh candidate held for four strobes; legal commit on the fourth.
  task automatic legal(input logic [3:0] an, input logic [6:0] seg, input int d,
                       input logic [3:0] nib, input logic fd);
    hold(an, seg, 3);
    cur_d[d*4 +: 4] = nib;
    cur_v[d]        = 1'b1;
    step(1'b1, an, seg, fd, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, 32'(bus.digits), 32'h0);
    check({tag, "_valid"}, 32'(bus.digit_valid), 32'h0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    check({tag, "_pattern_err"}, 32'(bus.pattern_err), 32'h0);
    check({tag, "_err_digit"}, 32'(bus.err_digit), 32'h0);
  endtask

  initial begin
    cur_d  = 16'h0;
    cur_v  = 4'h0;
    cur_ed = 2'd0;
    reset         = 1'b1;
    bus.sample_en = 1'b0;
    bus.an_in     = 4'hF;
    bus.seg_in    = 7'h7F;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Digit 0 shows 2; strobes 5..8 must not re-commit.
    legal(4'b1110, 7'h24, 0, 4'h2, 1'b0);
    hold(4'b1110, 7'h24, 4);
    idle(1);

    // Glitch on digit 1: 3x '3', one '4', then 4x '3' -> single commit of 3.
    hold(4'b1101, 7'h30, 3);
    hold(4'b1101, 7'h19, 1);
    legal(4'b1101, 7'h30, 1, 4'h3, 1'b0);

    // Full frame 1,A,D,F; mask already held digits 0 and 1.
    legal(4'b1110, 7'h79, 0, 4'h1, 1'b0);
    legal(4'b1101, 7'h08, 1, 4'hA, 1'b0);
    legal(4'b1011, 7'h21, 2, 4'hD, 1'b0);
    legal(4'b0111, 7'h0E, 3, 4'hF, 1'b1);
    idle(1);

    // Illegal pattern on digit 2, then blank on digit 3.
    hold(4'b1011, 7'h55, 3);
    cur_v[2] = 1'b0;
    cur_ed   = 2'd2;
    step(1'b1, 4'b1011, 7'h55, 1'b0, 1'b1);
    idle(1);
    hold(4'b0111, 7'h7F, 3);
    cur_v[3] = 1'b0;
    step(1'b1, 4'b0111, 7'h7F, 1'b0, 1'b0);
    idle(1);

    // Unqualified anodes restart the count; sample_en gaps do not.
    hold(4'b1110, 7'h40, 2);
    step(1'b1, 4'b1100, 7'h40, 1'b0, 1'b0);
    hold(4'b1110, 7'h40, 2);
    step(1'b1, 4'b1111, 7'h40, 1'b0, 1'b0);
    hold(4'b1110, 7'h40, 1);
    idle(2);
    hold(4'b1110, 7'h40, 1);
    idle(3);
    hold(4'b1110, 7'h40, 1);
    idle(1);
    cur_d[3:0] = 4'h0;
    cur_v[0]   = 1'b1;
    step(1'b1, 4'b1110, 7'h40, 1'b0, 1'b0);
    // Digit 1 completes the frame (blank digit 3 counted earlier).
    legal(4'b1101, 7'h12, 1, 4'h5, 1'b1);
    idle(1);

    // Reset mid-track at count 3: everything cleared, count restarts.
    hold(4'b1011, 7'h24, 3);
    @(negedge clk);
    bus.sample_en = 1'b0;
    reset = 1'b1;
    #1;
    check_zero("midreset");
    cur_d  = 16'h0;
    cur_v  = 4'h0;
    cur_ed = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    hold(4'b1011, 7'h24, 3);
    cur_d[11:8] = 4'h2;
    cur_v[2]    = 1'b1;
    step(1'b1, 4'b1011, 7'h24, 1'b0, 1'b0);
    idle(1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
